// File: rtl/rr_arb_ctrl.sv
// rr_arb_ctrl: round-robin arbiter with one-hot registered grant, hold limit and rotating priority
module rr_arb_ctrl #(
  parameter int N = 4,
  parameter int MAX_HOLD = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);
  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [N-1:0] grant_n;
  logic [IDW-1:0] id_n, ptr, ptr_n, win, nxt;
  logic [CW-1:0] hold_cnt, cnt_n;
  logic to_n, found;
  int idx;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && request[IDW'(idx)]) begin
        win = IDW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n = grant_id;
    ptr_n = ptr;
    cnt_n = hold_cnt;
    to_n = 1'b0;
    nxt = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    if (state == IDLE) begin
      if (found) begin
        state_n = GRANT;
        grant_n = N'(1) << win;
        id_n = win;
        cnt_n = CW'(1);
      end
    end else if (!request[grant_id]) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = nxt;
    end else if (MAX_HOLD != 0 && hold_cnt == CW'(MAX_HOLD)) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n = nxt;
      to_n = 1'b1;
    end else begin
      cnt_n = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      ptr <= '0;
      hold_cnt <= '0;
      timeout <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_id <= id_n;
      ptr <= ptr_n;
      hold_cnt <= cnt_n;
      timeout <= to_n;
      busy <= |grant_n;
    end
  end
endmodule

// File: tb/tb_rr_arb_ctrl.sv
// tb_rr_arb_ctrl: scoreboard bench with a cycle-level ownership model of the arbiter
module tb_rr_arb_ctrl;
  localparam int N = 4;
  localparam int MAX_HOLD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] grant;
  logic [1:0] grant_id;
  logic busy, timeout;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [N-1:0] grant;
    logic [1:0] id;
    logic busy;
    logic timeout;
    logic chk_id;
  } exp_t;
  exp_t sb[$];
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_id = 0;
  rr_arb_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .request(request), .grant(grant),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("grant", int'(grant), int'(e.grant));
      chk("busy", int'(busy), int'(e.busy));
      chk("timeout", int'(timeout), int'(e.timeout));
      if (e.chk_id) chk("grant_id", int'(grant_id), int'(e.id));
    end
  end
  task automatic step(input logic rs, input logic [N-1:0] r);
    exp_t e;
    rst = rs;
    request = r;
    e.timeout = 1'b0;
    e.chk_id = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr = 0;
      m_cnt = 0;
      m_id = 0;
      e.chk_id = 1'b1;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && r[2'((m_ptr + k) % N)]) m_owner = (m_ptr + k) % N;
      if (m_owner >= 0) begin
        m_cnt = 1;
        m_id = m_owner;
      end
    end else if (!r[2'(m_owner)]) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
      e.timeout = 1'b1;
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_cnt++;
    end
    e.busy = m_owner >= 0;
    e.grant = e.busy ? N'(1) << m_owner : '0;
    e.id = 2'(m_id);
    if (e.busy) e.chk_id = 1'b1;
    sb.push_back(e);
    @(negedge clk);
  endtask
  logic [4:0] dir[] = '{
    5'h1F, 5'h1F, 5'h0F, 5'h00,
    5'h10, 5'h05, 5'h04, 5'h04, 5'h00, 5'h00,
    5'h10, 5'h0F, 5'h0E, 5'h0F, 5'h0D, 5'h0F, 5'h0B, 5'h0F, 5'h07, 5'h0F, 5'h0F, 5'h00,
    5'h10, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h00, 5'h00,
    5'h01, 5'h01, 5'h01, 5'h01, 5'h00, 5'h01, 5'h01, 5'h00,
    5'h10, 5'h08, 5'h08, 5'h18, 5'h09, 5'h09, 5'h00
  };
  initial begin
    logic [N-1:0] r;
    foreach (dir[i]) step(dir[i][4], dir[i][3:0]);
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step($urandom_range(0, 59) == 0, r);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
